// File: rtl/dft_pkg.sv
// dft_pkg: state encoding, buffer op codes and sizing defaults shared by the
// scan-dump controller and its helpers.
package dft_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SREQ,
        S_SHIFT,
        S_RREQ,
        S_RWAIT,
        S_RSP,
        S_ERR
    } state_e;

    localparam logic OP_SHIFT = 1'b0;
    localparam logic OP_READ  = 1'b1;

    localparam int WORDS_MAX_DEF   = 64;
    localparam int ACK_TIMEOUT_DEF = 16;
    localparam int LEN_W           = 7;
    localparam int BIT_W           = 11;

    function automatic logic len_ok(input logic [LEN_W-1:0] len, input int words_max);
        return (len != '0) && (int'(len) <= words_max);
    endfunction

endpackage

// File: rtl/dft_timeout_cnt.sv
// dft_timeout_cnt: counts cycles spent waiting for an ack and flags the cycle
// on which the wait reaches TIMEOUT cycles.
module dft_timeout_cnt #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic clear,
    output logic expired
);

    localparam int W = $clog2(TIMEOUT + 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d   = clear ? '0 : run ? cnt_q + W'(1) : cnt_q;
        expired = run && (cnt_q == W'(TIMEOUT - 1));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/dft_ctrl.sv
// dft_ctrl: sequences a scan dump -- shift the chain into the SIPO buffer, then
// read it back word by word over a valid/ready response handshake.
module dft_ctrl
    import dft_pkg::*;
#(
    parameter int WORDS_MAX   = WORDS_MAX_DEF,
    parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_val,
    output logic             cmd_rdy,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             abort,
    output logic             rsp_val,
    input  logic             rsp_rdy,
    output logic             rsp_last,
    output logic             err,
    output logic             sc_sen,
    output logic             buf_sin_sel,
    output logic             buf_val_op,
    output logic             buf_op,
    input  logic             buf_op_ack,
    input  logic             buf_op_commit,
    input  logic             buf_scaning
);

    state_e           state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d, word_cnt_q, word_cnt_d;
    logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d, last_bit;
    logic             err_q, err_d;
    logic             accept, is_last, ack_wait, expired;

    always_comb begin
        accept   = (state_q == S_IDLE) && cmd_val;
        ack_wait = (state_q == S_SREQ) || (state_q == S_RREQ);
        is_last  = word_cnt_q == len_q - LEN_W'(1);
        last_bit = BIT_W'({len_q, 5'b0} - 12'd1);
    end

    dft_timeout_cnt #(
        .TIMEOUT (ACK_TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .run     (ack_wait),
        .clear   (!ack_wait),
        .expired (expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Abort wins over every other transition from a busy state.
    always_comb begin
        state_d = state_q;
        if (abort && state_q != S_IDLE) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (cmd_val) state_d = len_ok(cmd_len, WORDS_MAX) ? S_SREQ : S_ERR;
                S_SREQ:  state_d = buf_op_ack ? S_SHIFT : expired ? S_ERR : S_SREQ;
                S_SHIFT: state_d = (bit_cnt_q != '0 && !buf_scaning) ? S_ERR :
                                   (bit_cnt_q == last_bit) ? S_RREQ : S_SHIFT;
                S_RREQ:  state_d = buf_op_ack ? S_RWAIT : expired ? S_ERR : S_RREQ;
                S_RWAIT: state_d = buf_op_commit ? S_RSP : S_RWAIT;
                S_RSP:   state_d = !rsp_rdy ? S_RSP : is_last ? S_IDLE : S_RREQ;
                S_ERR:   state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        cmd_rdy     = state_q == S_IDLE;
        rsp_val     = state_q == S_RSP;
        rsp_last    = rsp_val && is_last;
        sc_sen      = state_q == S_SHIFT;
        buf_sin_sel = state_q == S_SHIFT;
        buf_val_op  = ack_wait;
        buf_op      = (state_q == S_RREQ) ? OP_READ : OP_SHIFT;
    end

    assign err = err_q;

    // err is raised on entry to ERR so it is visible while ERR is held.
    always_comb begin
        len_d      = accept ? cmd_len : len_q;
        bit_cnt_d  = (state_q == S_SHIFT) ? bit_cnt_q + BIT_W'(1) : '0;
        word_cnt_d = accept ? '0 :
                     (state_q == S_RSP && rsp_rdy) ? word_cnt_q + LEN_W'(1) : word_cnt_q;
        err_d      = (state_d == S_ERR) ? 1'b1 : accept ? 1'b0 : err_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            len_q      <= '0;
            bit_cnt_q  <= '0;
            word_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            len_q      <= len_d;
            bit_cnt_q  <= bit_cnt_d;
            word_cnt_q <= word_cnt_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: tb/tb_dft_ctrl.sv
// tb_dft_ctrl: directed scan-dump scenarios; the bench plays the datapath and
// scoreboards the expected rsp_last of every word it expects to receive.
module tb_dft_ctrl;

    logic       clk, reset, cmd_val, cmd_rdy, abort, rsp_val, rsp_rdy, rsp_last, err;
    logic [6:0] cmd_len;
    logic       sc_sen, buf_sin_sel, buf_val_op, buf_op;
    logic       buf_op_ack, buf_op_commit, buf_scaning;

    int  vectors = 0;
    int  miscompares = 0;
    int  sen, xfers, vrun, vops, rsps;
    bit  done;
    bit  exp_q[$];

    dft_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .cmd_val       (cmd_val),
        .cmd_rdy       (cmd_rdy),
        .cmd_len       (cmd_len),
        .abort         (abort),
        .rsp_val       (rsp_val),
        .rsp_rdy       (rsp_rdy),
        .rsp_last      (rsp_last),
        .err           (err),
        .sc_sen        (sc_sen),
        .buf_sin_sel   (buf_sin_sel),
        .buf_val_op    (buf_val_op),
        .buf_op        (buf_op),
        .buf_op_ack    (buf_op_ack),
        .buf_op_commit (buf_op_commit),
        .buf_scaning   (buf_scaning)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        assert (act === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, act, exp);
        end
    endtask

    // Issue one command and act as the datapath until the controller is idle again.
    task automatic run(input int len, input int sack, input int rack, input int cmt,
                       input bit tog, input int drop, input bit abrt);
        int wc = 0;
        int cc = 0;
        int cur = 0;
        bit t = 1'b1;
        bit lst;
        exp_q.delete();
        for (int i = 0; i < len; i++) exp_q.push_back(i == len - 1);
        sen = 0; xfers = 0; vrun = 0; vops = 0; rsps = 0; done = 0;
        @(negedge clk);
        check("cmd_rdy_idle", cmd_rdy, 1);
        cmd_val = 1'b1;
        cmd_len = 7'(len);
        @(negedge clk);
        cmd_val = 1'b0;
        check("err_on_accept", err, (len == 0 || len > 64) ? 1 : 0);
        for (int cyc = 0; cyc < 5000; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (cmd_rdy && cc == 0) begin
                done = 1;
                break;
            end
            buf_op_ack = 0; buf_op_commit = 0; abort = 0; buf_scaning = 1; rsp_rdy = 0;
            if (cc > 0) begin
                cc--;
                buf_op_commit = (cc == 0);
                abort = abrt && (cc == cmt - 1);
            end
            if (sc_sen) begin
                sen++;
                buf_scaning = (sen != drop);
            end
            if (buf_val_op) begin
                vops++;
                cur++;
                vrun = cur;
                buf_op_ack = (wc >= (buf_op ? rack : sack));
                wc = buf_op_ack ? 0 : wc + 1;
                if (buf_op_ack && buf_op) cc = cmt;
            end else begin
                cur = 0;
                wc = 0;
            end
            if (rsp_val) begin
                rsps++;
                rsp_rdy = tog ? t : 1'b1;
                t = ~t;
                if (rsp_rdy) begin
                    xfers++;
                    check("rsp_expected", exp_q.size() > 0, 1);
                    lst = (exp_q.size() > 0) ? exp_q.pop_front() : 1'b0;
                    check("rsp_last", rsp_last, lst);
                end
            end
        end
        buf_op_ack = 0; buf_op_commit = 0; abort = 0; rsp_rdy = 0; buf_scaning = 1;
        check("run_done", done, 1);
    endtask

    initial begin
        reset = 1'b1;
        cmd_val = 0; cmd_len = '0; abort = 0; rsp_rdy = 0;
        buf_op_ack = 0; buf_op_commit = 0; buf_scaning = 1;
        @(negedge clk);
        check("rst_sc_sen", sc_sen, 0);
        check("rst_buf_val_op", buf_val_op, 0);
        check("rst_rsp_val", rsp_val, 0);
        check("rst_err", err, 0);
        reset = 1'b0;

        run(1, 2, 2, 3, 0, 0, 0);
        check("len1_sen", sen, 32);
        check("len1_xfers", xfers, 1);
        check("len1_q", exp_q.size(), 0);
        check("len1_err", err, 0);

        run(64, 1, 0, 2, 1, 0, 0);
        check("len64_sen", sen, 2048);
        check("len64_xfers", xfers, 64);
        check("len64_q", exp_q.size(), 0);

        run(0, 0, 0, 1, 0, 0, 0);
        check("len0_vops", vops, 0);
        check("len0_err", err, 1);

        run(65, 0, 0, 1, 0, 0, 0);
        check("len65_vops", vops, 0);
        check("len65_err", err, 1);

        run(3, 0, 1, 1, 1, 0, 0);
        check("len3_sen", sen, 96);
        check("len3_xfers", xfers, 3);
        check("len3_q", exp_q.size(), 0);

        run(2, 100, 0, 1, 0, 0, 0);
        check("sreq_to_run", vrun, 16);
        check("sreq_to_err", err, 1);
        check("sreq_to_sen", sen, 0);

        run(1, 0, 100, 1, 0, 0, 0);
        check("rreq_to_run", vrun, 16);
        check("rreq_to_err", err, 1);
        check("rreq_to_sen", sen, 32);
        check("rreq_to_xfers", xfers, 0);

        run(4, 0, 0, 1, 0, 10, 0);
        check("drop_sen", sen, 10);
        check("drop_err", err, 1);
        check("drop_xfers", xfers, 0);

        run(2, 0, 0, 3, 0, 0, 1);
        check("abort_rsps", rsps, 0);
        check("abort_err", err, 0);
        check("abort_sen", sen, 64);

        @(negedge clk);
        cmd_val = 1'b1;
        cmd_len = 7'd4;
        @(negedge clk);
        cmd_val = 1'b0;
        buf_op_ack = 1'b1;
        @(negedge clk);
        buf_op_ack = 1'b0;
        repeat (99) @(negedge clk);
        check("shift100_sen", sc_sen, 1);
        #2 reset = 1'b1;
        #1;
        check("async_rst_sen", sc_sen, 0);
        check("async_rst_sin", buf_sin_sel, 0);
        check("async_rst_err", err, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_rdy", cmd_rdy, 1);
        check("post_rst_err", err, 0);
        check("post_rst_sen", sc_sen, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
